// File: rtl/sprite_line_fetcher.sv
// Sprite line fetcher: prefetches one 40-pixel sprite row per scanline from a
// one-cycle-latency sprite ROM into a line buffer, then serves pixels by DrawX.
//
// Ports:
//   Clk, Reset_n        system clock, asynchronous active-low reset
//   line_start          one-cycle pulse requesting a fetch for next_y
//   next_y, sprite_x,   scanline / sprite position, sampled on line_start
//   sprite_y
//   rom_addr, rom_data  ROM read port (registered address, data next cycle)
//   DrawX               current pixel column
//   pixel_idx, pixel_on palette index and opaque flag, one cycle after DrawX
//   busy                high while a row fetch is in progress
module sprite_line_fetcher #(
    parameter int          SPRITE_W    = 40,
    parameter int          SPRITE_H    = 40,
    parameter int          ADDR_W      = 11,
    parameter int          DATA_W      = 4,
    parameter logic [DATA_W-1:0] TRANSPARENT = 4'h0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              line_start,
    input  logic [9:0]        next_y,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic [9:0]        DrawX,
    output logic [DATA_W-1:0] pixel_idx,
    output logic              pixel_on,
    output logic              busy
);

    localparam int COL_W = $clog2(SPRITE_W);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(SPRITE_W - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [9:0]          r_row;
    logic [9:0]          r_x0;
    logic [COL_W-1:0]    r_col;
    logic                r_line_valid;
    logic [DATA_W-1:0]   r_buf [SPRITE_W];

    logic [9:0]          w_row;
    logic                w_row_hit;
    logic [ADDR_W-1:0]   w_row_a;
    logic [ADDR_W-1:0]   w_base;
    logic [ADDR_W-1:0]   w_addr;
    logic [9:0]          w_dx;
    logic                w_hit;
    logic [DATA_W-1:0]   w_pix;

    // Unsigned wrap turns rows above the sprite top into large values,
    // so a single compare rejects both sides.
    assign w_row     = next_y - sprite_y;
    assign w_row_hit = w_row < 10'(SPRITE_H);

    assign w_row_a = ADDR_W'(r_row);
    generate
        if (SPRITE_W == 40) begin : g_mul40
            assign w_base = (w_row_a << 5) + (w_row_a << 3);
        end else begin : g_mul
            assign w_base = w_row_a * ADDR_W'(SPRITE_W);
        end
    endgenerate
    assign w_addr = w_base + ADDR_W'(r_col);

    assign busy = (r_state != IDLE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // A new line_start always wins, including over DRAIN completion.
    always_comb begin
        w_next = r_state;
        if (line_start) begin
            w_next = w_row_hit ? FETCH : IDLE;
        end else begin
            unique case (r_state)
                FETCH:   if (r_col == LAST_COL) w_next = DRAIN;
                DRAIN:   w_next = IDLE;
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_x0         <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_line_valid <= 1'b0;
            rom_addr     <= '0;
        end else if (line_start) begin
            r_x0         <= sprite_x;
            r_row        <= w_row;
            r_col        <= '0;
            r_line_valid <= 1'b0;
        end else if (r_state == FETCH) begin
            rom_addr <= w_addr;
            r_col    <= r_col + COL_W'(1);
        end else if (r_state == DRAIN) begin
            r_line_valid <= 1'b1;
        end
    end

    // Data for the address issued last cycle lands one column behind.
    always_ff @(posedge Clk) begin
        if (r_state == FETCH && r_col != '0)
            r_buf[r_col - COL_W'(1)] <= rom_data;
        else if (r_state == DRAIN)
            r_buf[LAST_COL] <= rom_data;
    end

    assign w_dx  = DrawX - r_x0;
    assign w_hit = r_line_valid && (w_dx < 10'(SPRITE_W));
    assign w_pix = w_hit ? r_buf[w_dx[COL_W-1:0]] : '0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pixel_idx <= '0;
            pixel_on  <= 1'b0;
        end else begin
            pixel_idx <= w_pix;
            pixel_on  <= w_hit && (w_pix != TRANSPARENT);
        end
    end

endmodule
